mini_cpu_param: RTL and testbench

Parametrised multi-cycle mini processor: the next generation of the 4-bit, 4-register lab processor. Width, register count and program depth are parameters. It adds an internal program memory, an explicit fetch-decode-execute state machine, immediate loads, a conditional jump, an output port and halt. It is a standalone top-level block for the lab exercises, loaded through a program-write port and then run with `start`.

---
 rtl/mini_cpu_param_if.sv | 39 +++
 rtl/mini_cpu_param.sv | 165 ++++++++++++++++
 tb/tb_mini_cpu_param.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mini_cpu_param_if.sv
// Port bundle for mini_cpu_param: program loading, run control, debug read
// and architectural status. The slave modport is the processor; the master
// modport is whatever loads programs and watches the results.
interface mini_cpu_param_if #(
   parameter int WIDTH  = 8,
   parameter int NREGS  = 4,
   parameter int PDEPTH = 16
);
   localparam int RA = $clog2(NREGS);
   localparam int PA = $clog2(PDEPTH);
   localparam int IW = 3 + 2 * RA + WIDTH;

   logic             start;
   logic             prog_we;
   logic [PA-1:0]    prog_addr;
   logic [IW-1:0]    prog_data;
   logic [RA-1:0]    dbg_sel;
   logic [WIDTH-1:0] dbg_data;
   logic [WIDTH-1:0] result;
   logic             zero_flag;
   logic             carry_flag;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic [PA-1:0]    pc;
   logic             busy;
   logic             halted;

   modport master (
      output start, prog_we, prog_addr, prog_data, dbg_sel,
      input  dbg_data, result, zero_flag, carry_flag, out_data, out_valid,
             pc, busy, halted
   );

   modport slave (
      input  start, prog_we, prog_addr, prog_data, dbg_sel,
      output dbg_data, result, zero_flag, carry_flag, out_data, out_valid,
             pc, busy, halted
   );
endinterface

// File: rtl/mini_cpu_param.sv
// mini_cpu_param: parametrised multi-cycle processor. Each instruction runs
// FETCH -> DECODE -> EXECUTE; the program memory is loaded through the
// prog_* port while the core is not busy, then run from PC 0 with start.
// Instruction word: {op[2:0], rd, rs, imm}.
module mini_cpu_param #(
   parameter int WIDTH  = 8,
   parameter int NREGS  = 4,
   parameter int PDEPTH = 16
) (
   input logic             clk,
   input logic             reset,
   mini_cpu_param_if.slave bus
);
   localparam int RA = $clog2(NREGS);
   localparam int PA = $clog2(PDEPTH);
   localparam int IW = 3 + 2 * RA + WIDTH;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_HALTED
   } state_e;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_LDI  = 3'b100,
      OP_OUT  = 3'b101,
      OP_JZ   = 3'b110,
      OP_HALT = 3'b111
   } op_e;

   state_e           state, state_nxt;
   logic             busy, halted;

   logic [IW-1:0]    mem  [PDEPTH];
   logic [WIDTH-1:0] regs [NREGS];
   logic [IW-1:0]    ir;
   logic [PA-1:0]    pc;
   logic [WIDTH-1:0] opa, opb;
   logic [WIDTH-1:0] result_q, out_data_q;
   logic             zero_q, carry_q, out_valid_q;

   // Instruction fields
   op_e              op;
   logic [RA-1:0]    rd, rs;
   logic [WIDTH-1:0] imm;

   assign op  = op_e'(ir[IW-1 -: 3]);
   assign rd  = ir[IW-4 -: RA];
   assign rs  = ir[WIDTH+RA-1 -: RA];
   assign imm = ir[WIDTH-1:0];

   // ALU and write-back selection
   logic             alu_op, alu_c, reg_we;
   logic [WIDTH-1:0] alu_y, reg_wd;

   // ALU ops occupy opcodes 000..011, so the top opcode bit separates them.
   assign alu_op = ~ir[IW-1];
   assign reg_we = alu_op | (op == OP_LDI);
   assign reg_wd = (op == OP_LDI) ? imm : alu_y;

   // ALU on the DECODE-latched operands; carry is carry-out or borrow.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned, which would infer a latch.
      alu_y = '0;
      alu_c = 1'b0;
      case (op)
         OP_ADD:  {alu_c, alu_y} = {1'b0, opa} + {1'b0, opb};
         OP_SUB:  {alu_c, alu_y} = {1'b0, opa} - {1'b0, opb};
         OP_AND:  alu_y = opa & opb;
         OP_OR:   alu_y = opa | opb;
         default: ;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and status decode.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      halted    = 1'b0;
      case (state)
         S_IDLE:    if (bus.start) state_nxt = S_FETCH;
         S_FETCH:   begin busy = 1'b1; state_nxt = S_DECODE; end
         S_DECODE:  begin busy = 1'b1; state_nxt = S_EXECUTE; end
         S_EXECUTE: begin
            busy      = 1'b1;
            state_nxt = (op == OP_HALT) ? S_HALTED : S_FETCH;
         end
         S_HALTED:  begin
            halted = 1'b1;
            if (bus.start) state_nxt = S_FETCH;
         end
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Program memory write port, locked out while a program runs.
   // NOTE: program memory is deliberately not reset; a loaded program survives reset.
   always_ff @(posedge clk) begin
      if (bus.prog_we && !busy) mem[bus.prog_addr] <= bus.prog_data;
   end

   // Datapath: fetch, operand latch, and architectural updates in EXECUTE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= '0;
         ir          <= '0;
         opa         <= '0;
         opb         <= '0;
         result_q    <= '0;
         out_data_q  <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         out_valid_q <= 1'b0;
         case (state)
            S_IDLE, S_HALTED: if (bus.start) pc <= '0;
            S_FETCH: begin
               ir <= mem[pc];
               pc <= pc + PA'(1);
            end
            S_DECODE: begin
               opa <= regs[rd];
               opb <= regs[rs];
            end
            S_EXECUTE: begin
               if (reg_we) begin
                  regs[rd] <= reg_wd;
                  result_q <= reg_wd;
               end
               if (alu_op) begin
                  zero_q  <= (alu_y == '0);
                  carry_q <= alu_c;
               end
               if (op == OP_JZ && zero_q) pc <= imm[PA-1:0];
               if (op == OP_OUT) begin
                  out_data_q  <= opb;
                  out_valid_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.dbg_data   = regs[bus.dbg_sel];
   assign bus.result     = result_q;
   assign bus.zero_flag  = zero_q;
   assign bus.carry_flag = carry_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.pc         = pc;
   assign bus.busy       = busy;
   assign bus.halted     = halted;
endmodule

// File: tb/tb_mini_cpu_param.sv
// Testbench for mini_cpu_param (WIDTH=8, NREGS=4, PDEPTH=16): table of
// two-operand ALU programs plus hand-written multi-cycle sequences.
module tb_mini_cpu_param;
   localparam int WIDTH  = 8;
   localparam int NREGS  = 4;
   localparam int PDEPTH = 16;
   localparam int RA     = 2;
   localparam int PA     = 4;
   localparam int IW     = 3 + 2 * RA + WIDTH;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
   localparam logic [2:0] LDI = 3'b100, OUT = 3'b101, JZ = 3'b110, HALT = 3'b111;

   logic clk = 1'b0;
   logic reset;

   mini_cpu_param_if #(.WIDTH(WIDTH), .NREGS(NREGS), .PDEPTH(PDEPTH)) bus ();

   mini_cpu_param #(.WIDTH(WIDTH), .NREGS(NREGS), .PDEPTH(PDEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Per-cycle log of a run; index = cycles after the start edge.
   int         pc_log  [64];
   logic       z_log   [64];
   logic       c_log   [64];
   logic [7:0] dbg_log [64];
   int         halt_at, ov_count, ov_first;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] y;
      logic       z;
      logic       c;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] enc(input logic [2:0] op, input int rd, input int rs,
                                         input logic [7:0] imm);
      return {op, RA'(rd), RA'(rs), imm};
   endfunction

   task automatic load(input int addr, input logic [IW-1:0] word);
      bus.prog_we   = 1'b1;
      bus.prog_addr = PA'(addr);
      bus.prog_data = word;
      @(posedge clk); #1;
      bus.prog_we   = 1'b0;
   endtask

   // Pulse start, then log up to max_cyc cycles or until halted. At
   // inject_at a start + prog_we(word 0 := HALT) pulse is driven.
   task automatic run(input int max_cyc, input int inject_at);
      for (int i = 0; i < 64; i++) begin
         pc_log[i] = -1; z_log[i] = 1'bx; c_log[i] = 1'bx; dbg_log[i] = 8'hxx;
      end
      halt_at = -1; ov_count = 0; ov_first = -1;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.prog_we = 1'b0;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         @(posedge clk); #1;
         bus.start = 1'b0; bus.prog_we = 1'b0;
         pc_log[cyc]  = int'(bus.pc);
         z_log[cyc]   = bus.zero_flag;
         c_log[cyc]   = bus.carry_flag;
         dbg_log[cyc] = bus.dbg_data;
         if (bus.out_valid) begin
            ov_count++;
            if (ov_first < 0) ov_first = cyc;
         end
         if (bus.halted) begin
            halt_at = cyc;
            break;
         end
         if (cyc == inject_at) begin
            bus.start = 1'b1; bus.prog_we = 1'b1;
            bus.prog_addr = '0; bus.prog_data = enc(HALT, 0, 0, 8'h00);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{ADD,  8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
      vecs[1]  = '{ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
      vecs[2]  = '{AND_, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
      vecs[3]  = '{ADD,  8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
      vecs[4]  = '{ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
      vecs[5]  = '{SUB,  8'h03, 8'h08, 8'hFB, 1'b0, 1'b1};
      vecs[6]  = '{SUB,  8'h08, 8'h03, 8'h05, 1'b0, 1'b0};
      vecs[7]  = '{SUB,  8'h07, 8'h07, 8'h00, 1'b1, 1'b0};
      vecs[8]  = '{AND_, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0};
      vecs[9]  = '{OR_,  8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0};
      vecs[10] = '{OR_,  8'h00, 8'h00, 8'h00, 1'b1, 1'b0};

      bus.start = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0;
      bus.prog_data = '0; bus.dbg_sel = '0;

      // Reset and idle
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", bus.busy, 0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      check("idle_busy", bus.busy, 0);
      check("idle_halted", bus.halted, 0);
      check("idle_pc", bus.pc, 0);
      check("idle_result", bus.result, 0);
      check("idle_out_data", bus.out_data, 0);
      check("idle_out_valid", bus.out_valid, 0);
      check("idle_zero", bus.zero_flag, 0);
      check("idle_carry", bus.carry_flag, 0);
      check("idle_dbg", bus.dbg_data, 0);
      load(0, enc(LDI, 0, 0, 8'h05));
      check("load_stays_idle", {bus.busy, bus.halted}, 0);

      // Basic program: out_valid at cycle 12, halted at 15
      load(1, enc(LDI, 1, 0, 8'h03));
      load(2, enc(ADD, 0, 1, 8'h00));
      load(3, enc(OUT, 0, 0, 8'h00));
      load(4, enc(HALT, 0, 0, 8'h00));
      bus.dbg_sel = 2'd0;
      run(40, -1);
      check("basic_ov_cycle", ov_first, 12);
      check("basic_ov_count", ov_count, 1);
      check("basic_halt_cycle", halt_at, 15);
      check("basic_out_data", bus.out_data, 8'h08);
      check("basic_dbg_r0", bus.dbg_data, 8'h08);
      check("basic_result", bus.result, 8'h08);

      // ALU table: LDI R0,a; LDI R1,b; op R0,R1; HALT
      for (int v = 0; v < 11; v++) begin
         load(0, enc(LDI, 0, 0, vecs[v].a));
         load(1, enc(LDI, 1, 0, vecs[v].b));
         load(2, enc(vecs[v].op, 0, 1, 8'h00));
         load(3, enc(HALT, 0, 0, 8'h00));
         bus.dbg_sel = 2'd0;
         run(40, -1);
         check($sformatf("vec%0d_halt", v), halt_at, 12);
         check($sformatf("vec%0d_result", v), bus.result, vecs[v].y);
         check($sformatf("vec%0d_dbg", v), bus.dbg_data, vecs[v].y);
         check($sformatf("vec%0d_zero", v), bus.zero_flag, vecs[v].z);
         check($sformatf("vec%0d_carry", v), bus.carry_flag, vecs[v].c);
      end

      // SUB with borrow, then rd == rs
      load(0, enc(LDI, 0, 0, 8'h08));
      load(1, enc(LDI, 1, 0, 8'h03));
      load(2, enc(SUB, 1, 0, 8'h00));
      load(3, enc(OUT, 0, 1, 8'h00));
      load(4, enc(SUB, 1, 1, 8'h00));
      load(5, enc(HALT, 0, 0, 8'h00));
      bus.dbg_sel = 2'd1;
      run(40, -1);
      check("sub_r1_after", dbg_log[9], 8'hFB);
      check("sub_carry", c_log[9], 1);
      check("sub_zero", z_log[9], 0);
      check("sub_out_data", bus.out_data, 8'hFB);
      check("sub_ov_cycle", ov_first, 12);
      check("subself_r1", bus.dbg_data, 8'h00);
      check("subself_zero", bus.zero_flag, 1);
      check("subself_carry", bus.carry_flag, 0);
      check("subself_halt", halt_at, 18);

      // JZ not taken, then taken
      load(0, enc(LDI, 0, 0, 8'h01));
      load(1, enc(LDI, 1, 0, 8'h01));
      load(2, enc(ADD, 0, 1, 8'h00));
      load(3, enc(JZ, 0, 0, 8'h0A));
      load(4, enc(LDI, 2, 0, 8'h11));
      load(5, enc(HALT, 0, 0, 8'h00));
      load(10, enc(LDI, 2, 0, 8'h22));
      load(11, enc(HALT, 0, 0, 8'h00));
      bus.dbg_sel = 2'd2;
      run(40, -1);
      check("jznt_pc", pc_log[12], 4);
      check("jznt_r2", bus.dbg_data, 8'h11);
      check("jznt_zero", bus.zero_flag, 0);
      check("jznt_halt", halt_at, 18);
      load(0, enc(LDI, 0, 0, 8'hFF));
      run(40, -1);
      check("jz_pc", pc_log[12], 10);
      check("jz_r2", bus.dbg_data, 8'h22);
      check("jz_result", bus.result, 8'h22);
      check("jz_zero_kept", bus.zero_flag, 1);
      check("jz_carry_kept", bus.carry_flag, 1);
      check("jz_halt", halt_at, 18);

      // 16-word program without HALT; start and prog_we while busy
      for (int i = 0; i < 16; i++) load(i, enc(LDI, 3, 0, 8'(8'h10 + i)));
      bus.dbg_sel = 2'd3;
      run(52, 5);
      check("busy_no_restart_pc", pc_log[7], 3);
      check("wrap_pc_before", pc_log[45], 15);
      check("wrap_pc", pc_log[46], 0);
      check("wrap_r3_last", dbg_log[48], 8'h1F);
      check("wrap_r3_first", dbg_log[51], 8'h10);
      check("busy_mem_unchanged", halt_at, -1);

      // Asynchronous reset during EXECUTE
      @(posedge clk); #1;
      check("pre_reset_busy", bus.busy, 1);
      #2 reset = 1'b0;
      #1;
      check("arst_busy", bus.busy, 0);
      check("arst_pc", bus.pc, 0);
      check("arst_result", bus.result, 0);
      check("arst_r3", bus.dbg_data, 0);
      check("arst_out_data", bus.out_data, 0);
      check("arst_flags", {bus.zero_flag, bus.carry_flag, bus.halted, bus.out_valid}, 0);
      @(negedge clk) reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_reset_idle", bus.busy, 0);
      check("post_reset_pc", bus.pc, 0);

      // Rerun from PC 0; word 0 written in the same cycle as start
      load(1, enc(LDI, 1, 0, 8'h03));
      load(2, enc(ADD, 0, 1, 8'h00));
      load(3, enc(OUT, 0, 0, 8'h00));
      load(4, enc(HALT, 0, 0, 8'h00));
      bus.prog_we = 1'b1; bus.prog_addr = '0; bus.prog_data = enc(LDI, 0, 0, 8'h05);
      bus.dbg_sel = 2'd0;
      run(40, -1);
      check("rerun_out_data", bus.out_data, 8'h08);
      check("rerun_ov_cycle", ov_first, 12);
      check("rerun_halt", halt_at, 15);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
